// File: rtl/fifo_read_consumer_if.sv
// FIFO read-port handshake between the read-side consumer (master) and the FIFO (slave).
interface fifo_read_consumer_if #(
  parameter int unsigned K = 4
) ();
  logic         empty;
  logic [K-1:0] data;
  logic         read;

  modport master (input empty, input data, output read);
  modport slave  (output empty, output data, input read);
endinterface

// File: rtl/fifo_read_consumer.sv
// Read-side FIFO consumer: paced single-word reads, local capture memory,
// XOR checksum and word count, sticky DONE after M words.
module fifo_read_consumer #(
  parameter  int unsigned K  = 4,
  parameter  int unsigned M  = 6,
  parameter  int unsigned P  = 2,
  localparam int unsigned CW = $clog2(M + 1),
  localparam int unsigned AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          read_clk,
  input  logic          rst,
  fifo_read_consumer_if.master fifo,
  output logic [K-1:0]  siu,
  output logic [CW-1:0] count,
  output logic [K-1:0]  checksum,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [K-1:0]  mem_q
);

  localparam int unsigned PW = (P > 2) ? $clog2(P) : 1;
  // PACE is only entered for P >= 2, so the P == 1 value is never used.
  localparam logic [PW-1:0] PACE_INIT = (P >= 2) ? PW'(P - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_PACE    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          read_nxt;
  logic          done_nxt;
  logic [PW-1:0] pace_cnt;
  logic [K-1:0]  mem [M];

  // State register with registered handshake/status outputs
  always_ff @(posedge read_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fifo.read <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      fifo.read <= read_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    state_nxt = S_ARM;
      S_ARM:     state_nxt = fifo.empty ? S_ARM : S_READ;
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (count == CW'(M - 1))
          state_nxt = S_DONE;
        else if (P == 1)
          state_nxt = S_ARM;
        else
          state_nxt = S_PACE;
      end
      S_PACE:    state_nxt = (pace_cnt == '0) ? S_ARM : S_PACE;
      S_DONE:    state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so read/done are registered
  always_comb begin
    read_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == S_READ) read_nxt = 1'b1;
    if (state_nxt == S_DONE) done_nxt = 1'b1;
  end

  // Capture datapath and pace counter
  always_ff @(posedge read_clk) begin
    if (rst) begin
      siu      <= '0;
      count    <= '0;
      checksum <= '0;
      pace_cnt <= '0;
    end else begin
      if (state == S_CAPTURE) begin
        siu      <= fifo.data;
        count    <= count + CW'(1);
        checksum <= checksum ^ fifo.data;
        pace_cnt <= PACE_INIT;
      end else if (state == S_PACE && pace_cnt != '0) begin
        pace_cnt <= pace_cnt - PW'(1);
      end
    end
  end

  // Local memory is not cleared by reset; a capture coincident with reset is dropped
  always_ff @(posedge read_clk) begin
    if (!rst && state == S_CAPTURE)
      mem[count[AW-1:0]] <= fifo.data;
  end

  assign mem_q = mem[rd_addr];

endmodule
